// File: rtl/pong_pkg.sv
// Shared types and defaults for the PONG game-mode sequencer.
package pong_pkg;

    typedef enum logic [1:0] {
        MODE_MENU  = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_PAUSE = 2'd2,
        MODE_OVER  = 2'd3
    } mode_e;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned FCNT_W  = 8;

    localparam int unsigned START_X0_DEF    = 412;
    localparam int unsigned START_X1_DEF    = 611;
    localparam int unsigned START_Y0_DEF    = 334;
    localparam int unsigned START_Y1_DEF    = 433;
    localparam int unsigned WIN_SCORE       = 9;
    localparam int unsigned OVER_FRAMES_DEF = 180;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } mouse_pos_t;

    // Inclusive range test on a screen coordinate.
    function automatic logic in_range(input logic [COORD_W-1:0] v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) <= hi);
    endfunction

endpackage

// File: rtl/pong_mode_ctl_if.sv
// Mouse/score/vsync inputs and mode outputs of the PONG mode sequencer.
interface pong_mode_if;
    import pong_pkg::*;

    logic               vsync_in;
    logic               mouse_left;
    logic [COORD_W-1:0] xpos;
    logic [COORD_W-1:0] ypos;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    mode_e              mode;
    logic               game_run;
    logic               menu_sel;
    logic               score_clr;

    modport master (
        output vsync_in, mouse_left, xpos, ypos, score_l, score_r,
        input  mode, game_run, menu_sel, score_clr
    );

    modport slave (
        input  vsync_in, mouse_left, xpos, ypos, score_l, score_r,
        output mode, game_run, menu_sel, score_clr
    );

endinterface

// File: rtl/click_latch.sv
// Mouse click edge detect plus per-frame click request / START-box hit latches.
module click_latch import pong_pkg::*; #(
    parameter int unsigned X0 = START_X0_DEF,
    parameter int unsigned X1 = START_X1_DEF,
    parameter int unsigned Y0 = START_Y0_DEF,
    parameter int unsigned Y1 = START_Y1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mouse_left,
    input  mouse_pos_t pos,
    input  logic       clear,
    output logic       click_pend,
    output logic       click_hit
);

    logic mouse_q, mouse_d;
    logic pend_q, pend_d;
    logic hit_q, hit_d;
    logic click_c, in_box_c;

    // Clear first so a click coinciding with the frame edge seeds the next frame.
    always_comb begin
        mouse_d  = mouse_left;
        click_c  = mouse_left & ~mouse_q;
        in_box_c = in_range(pos.x, X0, X1) && in_range(pos.y, Y0, Y1);
        pend_d   = pend_q;
        hit_d    = hit_q;
        if (clear) begin
            pend_d = 1'b0;
            hit_d  = 1'b0;
        end
        if (click_c) begin
            pend_d = 1'b1;
            hit_d  = hit_d | in_box_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mouse_q <= 1'b0;
            pend_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            mouse_q <= mouse_d;
            pend_q  <= pend_d;
            hit_q   <= hit_d;
        end
    end

    assign click_pend = pend_q;
    assign click_hit  = hit_q;

endmodule

// File: rtl/pong_mode_ctl.sv
// PONG game-mode sequencer: MENU/PLAY/PAUSE/OVER, switching only on vsync rising edges.
// Optional PAUSE support is enabled by defining PONG_PAUSE_EN.
module pong_mode_ctl import pong_pkg::*; #(
    parameter int unsigned START_X0    = START_X0_DEF,
    parameter int unsigned START_X1    = START_X1_DEF,
    parameter int unsigned START_Y0    = START_Y0_DEF,
    parameter int unsigned START_Y1    = START_Y1_DEF,
    parameter int unsigned WIN_SCORE   = pong_pkg::WIN_SCORE,
    parameter int unsigned OVER_FRAMES = OVER_FRAMES_DEF
) (
    input logic        clk,
    input logic        rst,
    pong_mode_if.slave bus
);

`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic              vsync_q, vsync_d;
    mode_e             mode_q, mode_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              game_run_q, game_run_d;
    logic              menu_sel_q, menu_sel_d;
    logic              score_clr_q, score_clr_d;
    logic              frame_edge_c, score_won_c;
    logic              click_pend, click_hit;
    mouse_pos_t        pos_c;

    assign pos_c        = '{x: bus.xpos, y: bus.ypos};
    assign frame_edge_c = bus.vsync_in & ~vsync_q;
    assign score_won_c  = (bus.score_l >= SCORE_W'(WIN_SCORE)) ||
                          (bus.score_r >= SCORE_W'(WIN_SCORE));

    click_latch #(
        .X0 (START_X0),
        .X1 (START_X1),
        .Y0 (START_Y0),
        .Y1 (START_Y1)
    ) u_click_latch (
        .clk        (clk),
        .rst        (rst),
        .mouse_left (bus.mouse_left),
        .pos        (pos_c),
        .clear      (frame_edge_c),
        .click_pend (click_pend),
        .click_hit  (click_hit)
    );

    // Next mode is only evaluated on a frame edge; outputs decode from the next mode.
    always_comb begin
        vsync_d     = bus.vsync_in;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        score_clr_d = 1'b0;
        if (frame_edge_c) begin
            case (mode_q)
                MODE_MENU: begin
                    if (click_pend && click_hit) begin
                        mode_d      = MODE_PLAY;
                        score_clr_d = 1'b1;
                    end
                end
                MODE_PLAY: begin
                    if (score_won_c) begin
                        mode_d      = MODE_OVER;
                        frame_cnt_d = '0;
                    end else if (PAUSE_EN && click_pend) begin
                        mode_d = MODE_PAUSE;
                    end
                end
                MODE_PAUSE: begin
                    if (click_pend || !PAUSE_EN) mode_d = MODE_PLAY;
                end
                MODE_OVER: begin
                    if (32'(frame_cnt_q) + 32'd1 >= OVER_FRAMES) begin
                        mode_d      = MODE_MENU;
                        frame_cnt_d = '0;
                    end else if (frame_cnt_q != '1) begin
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    end
                end
                default: mode_d = MODE_MENU;
            endcase
        end
        game_run_d = (mode_d == MODE_PLAY);
        menu_sel_d = (mode_d == MODE_MENU) || (mode_d == MODE_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q     <= 1'b0;
            mode_q      <= MODE_MENU;
            frame_cnt_q <= '0;
            game_run_q  <= 1'b0;
            menu_sel_q  <= 1'b1;
            score_clr_q <= 1'b0;
        end else begin
            vsync_q     <= vsync_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            game_run_q  <= game_run_d;
            menu_sel_q  <= menu_sel_d;
            score_clr_q <= score_clr_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.game_run  = game_run_q;
    assign bus.menu_sel  = menu_sel_q;
    assign bus.score_clr = score_clr_q;

endmodule

// File: tb/tb_pong_mode_ctl.sv
// Self-checking bench for pong_mode_ctl: directed scenarios plus randomized frames
// compared against a frame-level behavioural model of the game rules.
module tb_pong_mode_ctl;

    localparam int FL    = 20;   // clocks per frame
    localparam int VS_HI = 3;    // vsync high clocks per frame
    localparam int OVF   = 180;
    localparam int WIN   = 9;
`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    pong_mode_if bus();

    pong_mode_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass, n_fail, n_total;
    int phase;

    // Reference model: mode as 0..3, clicks/hits counted per frame, frames spent in OVER.
    int m_mode, m_cnt, m_clicks, m_hits;
    bit m_prev_vs, m_prev_ms, m_clr;

    function automatic bit in_box(input int x, input int y);
        return (x >= 412) && (x <= 611) && (y >= 334) && (y <= 433);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_clicks = 0; m_hits = 0;
        m_prev_vs = 0; m_prev_ms = 0; m_clr = 0;
    endtask

    task automatic model_step();
        bit fe, ce;
        fe = bus.vsync_in && !m_prev_vs;
        ce = bus.mouse_left && !m_prev_ms;
        m_clr = 0;
        if (fe) begin
            if (m_mode == 0) begin
                if (m_clicks > 0 && m_hits > 0) begin m_mode = 1; m_clr = 1; end
            end else if (m_mode == 1) begin
                if (int'(bus.score_l) >= WIN || int'(bus.score_r) >= WIN) begin
                    m_mode = 3; m_cnt = 0;
                end else if (PAUSE_ON && m_clicks > 0) m_mode = 2;
            end else if (m_mode == 2) begin
                if (!PAUSE_ON || m_clicks > 0) m_mode = 1;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == OVF) begin m_mode = 0; m_cnt = 0; end
            end
            m_clicks = 0;
            m_hits   = 0;
        end
        if (ce) begin
            m_clicks = m_clicks + 1;
            if (in_box(int'(bus.xpos), int'(bus.ypos))) m_hits = m_hits + 1;
        end
        m_prev_vs = bus.vsync_in;
        m_prev_ms = bus.mouse_left;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_total++;
        assert (obs === 32'(exp)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_mode"},      32'(bus.mode),         m_mode);
        chk({tag, "_game_run"},  32'(bus.game_run),     int'(m_mode == 1));
        chk({tag, "_menu_sel"},  32'(bus.menu_sel),     int'(m_mode == 0 || m_mode == 3));
        chk({tag, "_score_clr"}, 32'(bus.score_clr),    int'(m_clr));
        chk({tag, "_frame_cnt"}, 32'(dut.frame_cnt_q),  m_cnt);
    endtask

    // One clock: drive vsync for this phase, clock, advance model, check.
    task automatic step();
        bus.vsync_in = (phase % FL) < VS_HI;
        @(posedge clk);
        if (rst) model_step(); else model_reset();
        #1;
        check_outputs("cyc");
        phase++;
    endtask

    // Run through the next frame edge; returns just after it has taken effect.
    task automatic to_edge();
        do step(); while ((phase % FL) != 1);
    endtask

    task automatic click(input int x, input int y);
        bus.xpos = 12'(x);
        bus.ypos = 12'(y);
        bus.mouse_left = 1'b1;
        step();
        bus.mouse_left = 1'b0;
        step();
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0; phase = 0;
        rst = 1'b0;
        bus.vsync_in = 1'b0; bus.mouse_left = 1'b0;
        bus.xpos = '0; bus.ypos = '0; bus.score_l = '0; bus.score_r = '0;
        model_reset();

        // Reset values, then idle frames.
        repeat (4) step();
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_menu_sel", 32'(bus.menu_sel), 1);
        chk("rst_game_run", 32'(bus.game_run), 0);
        chk("rst_score_clr", 32'(bus.score_clr), 0);
        rst = 1'b1;
        repeat (3) to_edge();
        chk("idle_mode", 32'(bus.mode), 0);
        chk("idle_menu_sel", 32'(bus.menu_sel), 1);

        // Misses (including just outside the box) are discarded at the edge.
        click(100, 100);
        to_edge();
        chk("miss_mode", 32'(bus.mode), 0);
        to_edge();
        chk("miss_dropped", 32'(bus.mode), 0);
        click(411, 380);
        click(500, 434);
        to_edge();
        chk("miss_border", 32'(bus.mode), 0);

        // Corner hit starts a game; score_clr is a single-cycle pulse.
        click(412, 334);
        to_edge();
        chk("hit_mode", 32'(bus.mode), 1);
        chk("hit_score_clr", 32'(bus.score_clr), 1);
        chk("hit_menu_sel", 32'(bus.menu_sel), 0);
        step();
        chk("clr_pulse_end", 32'(bus.score_clr), 0);

        // Pause and resume (pause only exists with the macro).
        click(300, 50);
        to_edge();
        chk("pause_mode", 32'(bus.mode), PAUSE_ON ? 2 : 1);
        chk("pause_run", 32'(bus.game_run), PAUSE_ON ? 0 : 1);
        click(700, 50);
        click(710, 60);
        to_edge();
        chk("resume_mode", 32'(bus.mode), 1);
        chk("resume_run", 32'(bus.game_run), 1);

        // Win beats pause; OVER holds 180 frames ignoring clicks.
        bus.score_r = 4'(WIN);
        click(500, 380);
        to_edge();
        chk("win_mode", 32'(bus.mode), 3);
        chk("win_menu_sel", 32'(bus.menu_sel), 1);
        bus.score_r = '0;
        click(500, 380);
        repeat (OVF - 1) to_edge();
        chk("over_hold", 32'(bus.mode), 3);
        chk("over_cnt", 32'(dut.frame_cnt_q), OVF - 1);
        to_edge();
        chk("over_exit", 32'(bus.mode), 0);
        chk("over_cnt_clr", 32'(dut.frame_cnt_q), 0);

        // Click landing on the frame-edge cycle counts for the following frame.
        while ((phase % FL) != 0) step();
        bus.xpos = 12'(611); bus.ypos = 12'(433); bus.mouse_left = 1'b1;
        step();
        chk("edge_click_now", 32'(bus.mode), 0);
        bus.mouse_left = 1'b0;
        to_edge();
        chk("edge_click_next", 32'(bus.mode), 1);

        // Asynchronous reset in the middle of OVER.
        bus.score_l = 4'(15);
        to_edge();
        chk("over2_mode", 32'(bus.mode), 3);
        bus.score_l = '0;
        repeat (90) to_edge();
        chk("over2_cnt", 32'(dut.frame_cnt_q), 90);
        repeat (7) step();
        rst = 1'b0;
        #1;
        chk("arst_mode", 32'(bus.mode), 0);
        chk("arst_cnt", 32'(dut.frame_cnt_q), 0);
        chk("arst_menu_sel", 32'(bus.menu_sel), 1);
        model_reset();
        repeat (3) step();
        rst = 1'b1;
        click(450, 400);
        to_edge();
        chk("post_rst_play", 32'(bus.mode), 1);

        // Randomized frames: clicks anywhere (including on edges), occasional wins and resets.
        for (int f = 0; f < 120; f++) begin
            if ($urandom_range(0, 9) == 0) bus.score_r = 4'($urandom_range(9, 15));
            else begin
                bus.score_l = 4'($urandom_range(0, 8));
                bus.score_r = 4'($urandom_range(0, 8));
            end
            for (int c = 0; c < FL; c++) begin
                bus.mouse_left = ($urandom_range(0, 5) == 0);
                bus.xpos = 12'($urandom_range(380, 650));
                bus.ypos = 12'($urandom_range(300, 470));
                if (c == 9 && $urandom_range(0, 29) == 0) begin
                    rst = 1'b0;
                    #1;
                    model_reset();
                    check_outputs("rand_arst");
                    step();
                    rst = 1'b1;
                end
                step();
            end
        end
        bus.mouse_left = 1'b0;
        repeat (FL) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
